// File: rtl/receive_shift_register.sv
// receive_shift_register: serial-to-parallel receiver with a two-entry output buffer.
// Frame on the line: start 1, DATA_WIDTH data bits (LSB first), even parity bit, stop 0.
// Ports:
//   clk, rst_n     - system clock, asynchronous active-low reset
//   serial_data    - serial line, sampled only on cycles with shift=1
//   shift          - bit strobe, one line bit consumed per strobe
//   paralel_data   - head word of the output buffer, 0 when empty
//   data_valid     - output buffer non-empty
//   data_ack       - pops the head word, ignored when the buffer is empty
//   parity_error   - one-cycle pulse, frame dropped on parity mismatch
//   framing_error  - one-cycle pulse, frame dropped on bad stop bit
//   overrun_error  - one-cycle pulse, good frame dropped because the buffer was full
module receive_shift_register #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  serial_data,
  input  logic                  shift,
  output logic [DATA_WIDTH-1:0] paralel_data,
  output logic                  data_valid,
  input  logic                  data_ack,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  overrun_error
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]            state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DATA_WIDTH-1:0] sreg, sreg_n;
  logic                  par_ok, par_ok_n;
  logic [DATA_WIDTH-1:0] head_n;
  logic [DATA_WIDTH-1:0] tail, tail_n;
  logic [1:0]            count, count_n;
  logic                  perr_n, ferr_n, oerr_n;
  logic                  push_c, pop_c;

  // Frame delineation: advances only on strobed cycles.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sreg_n   = sreg;
    par_ok_n = par_ok;
    push_c   = 1'b0;
    perr_n   = 1'b0;
    ferr_n   = 1'b0;
    if (shift) begin
      case (state)
        IDLE: begin
          if (serial_data) begin
            state_n = DATA;
            cnt_n   = '0;
            sreg_n  = '0;
          end
        end
        DATA: begin
          sreg_n = {serial_data, sreg[DATA_WIDTH-1:1]};
          // Counter saturates at the last data bit so it never wraps inside a frame.
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            state_n = PARITY;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        PARITY: begin
          par_ok_n = (serial_data == ^sreg);
          state_n  = STOP;
        end
        STOP: begin
          // Framing error wins over parity; the stop bit never starts a new frame.
          state_n = IDLE;
          if (serial_data) begin
            ferr_n = 1'b1;
          end else if (!par_ok) begin
            perr_n = 1'b1;
          end else begin
            push_c = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Two-entry buffer: head lives in the paralel_data register, cleared when it empties.
  always_comb begin
    pop_c   = data_ack && (count != 2'd0);
    head_n  = paralel_data;
    tail_n  = tail;
    count_n = count;
    oerr_n  = 1'b0;
    case ({push_c, pop_c})
      2'b01: begin
        head_n  = tail;
        tail_n  = '0;
        count_n = count - 2'd1;
      end
      2'b10: begin
        if (count == 2'd0) begin
          head_n  = sreg;
          count_n = 2'd1;
        end else if (count == 2'd1) begin
          tail_n  = sreg;
          count_n = 2'd2;
        end else begin
          oerr_n = 1'b1;
        end
      end
      2'b11: begin
        // The pop frees a slot, so a push at count 2 is not an overrun.
        if (count == 2'd1) begin
          head_n = sreg;
        end else begin
          head_n = tail;
          tail_n = sreg;
        end
      end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      sreg          <= '0;
      par_ok        <= 1'b0;
      paralel_data  <= '0;
      tail          <= '0;
      count         <= 2'd0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      sreg          <= sreg_n;
      par_ok        <= par_ok_n;
      paralel_data  <= head_n;
      tail          <= tail_n;
      count         <= count_n;
      data_valid    <= (count_n != 2'd0);
      parity_error  <= perr_n;
      framing_error <= ferr_n;
      overrun_error <= oerr_n;
    end
  end

endmodule

// File: tb/tb_receive_shift_register.sv
// tb_receive_shift_register: directed and randomized frames checked against a
// frame-level model (a word queue plus per-frame error prediction).
module tb_receive_shift_register;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         serial_data;
  logic         shift;
  logic [W-1:0] paralel_data;
  logic         data_valid;
  logic         data_ack;
  logic         parity_error;
  logic         framing_error;
  logic         overrun_error;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] q[$];

  receive_shift_register #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .serial_data   (serial_data),
    .shift         (shift),
    .paralel_data  (paralel_data),
    .data_valid    (data_valid),
    .data_ack      (data_ack),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun_error (overrun_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all outputs against the model queue and the predicted pulses.
  task automatic check_outputs(input string tag, input bit ep, input bit ef, input bit eo);
    logic [W-1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    check({tag, ".valid"}, 32'(data_valid), 32'(q.size() > 0));
    check({tag, ".data"}, 32'(paralel_data), 32'(head));
    check({tag, ".perr"}, 32'(parity_error), 32'(ep));
    check({tag, ".ferr"}, 32'(framing_error), 32'(ef));
    check({tag, ".oerr"}, 32'(overrun_error), 32'(eo));
  endtask

  // Send one frame. gmax bounds random no-strobe gaps before each bit;
  // ack_stop asserts data_ack on the stop-bit edge.
  task automatic send_frame(input string tag, input logic [W-1:0] d, input bit par_flip,
                            input bit stop, input int gmax, input bit ack_stop);
    logic [W+2:0] bits;
    int           ng;
    bit           ep, ef, eo;
    bits = {stop, (^d) ^ par_flip, d, 1'b1};
    for (int i = 0; i < W + 3; i++) begin
      ng = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      for (int g = 0; g < ng; g++) begin
        shift       = 1'b0;
        serial_data = 1'($urandom);
        @(posedge clk); #1;
        check_outputs({tag, ".gap"}, 1'b0, 1'b0, 1'b0);
      end
      shift       = 1'b1;
      serial_data = bits[i];
      data_ack    = (i == W + 2) ? ack_stop : 1'b0;
      @(posedge clk); #1;
      shift    = 1'b0;
      data_ack = 1'b0;
      if (i < W + 2) begin
        check_outputs({tag, ".bit"}, 1'b0, 1'b0, 1'b0);
      end else begin
        ef = stop;
        ep = !stop && par_flip;
        eo = 1'b0;
        if (ack_stop && q.size() > 0) void'(q.pop_front());
        if (!ef && !ep) begin
          if (q.size() < 2) q.push_back(d);
          else eo = 1'b1;
        end
        check_outputs({tag, ".stop"}, ep, ef, eo);
      end
    end
  endtask

  task automatic pop(input string tag);
    data_ack = 1'b1;
    @(posedge clk); #1;
    data_ack = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check_outputs(tag, 1'b0, 1'b0, 1'b0);
  endtask

  // Strobed zeros on the idle line must not start a frame.
  task automatic idle_zeros(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      shift       = 1'b1;
      serial_data = 1'b0;
      @(posedge clk); #1;
      shift = 1'b0;
      check_outputs(tag, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] d;
    bit           pf, sb, ak;
    rst_n       = 1'b0;
    serial_data = 1'b0;
    shift       = 1'b0;
    data_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame, then one ack empties the buffer.
    send_frame("basic", 8'hA5, 1'b0, 1'b0, 0, 1'b0);
    check("basic.word", 32'(paralel_data), 32'h0000_00A5);
    @(posedge clk); #1;
    check_outputs("basic.pulse_gone", 1'b0, 1'b0, 1'b0);
    pop("basic.ack");
    pop("empty.ack");

    // Gapped strobe with noise on the line between strobes.
    send_frame("gapped", 8'hA5, 1'b0, 1'b0, 5, 1'b0);
    pop("gapped.ack");

    // Parity error followed by a good frame.
    send_frame("perr", 8'h01, 1'b1, 1'b0, 0, 1'b0);
    send_frame("after_perr", 8'h03, 1'b0, 1'b0, 0, 1'b0);
    pop("after_perr.ack");

    // Framing error, then zeros that must not start a frame.
    send_frame("ferr", 8'h5A, 1'b0, 1'b1, 0, 1'b0);
    idle_zeros("ferr.idle", 3);
    send_frame("after_ferr", 8'h3C, 1'b0, 1'b0, 0, 1'b0);
    pop("after_ferr.ack");

    // Overrun without ack, then the same with ack on the third push.
    send_frame("ovr1", 8'h11, 1'b0, 1'b0, 0, 1'b0);
    send_frame("ovr2", 8'h22, 1'b0, 1'b0, 0, 1'b0);
    send_frame("ovr3", 8'h33, 1'b0, 1'b0, 0, 1'b0);
    pop("ovr.ack1");
    pop("ovr.ack2");
    send_frame("noovr1", 8'h11, 1'b0, 1'b0, 0, 1'b0);
    send_frame("noovr2", 8'h22, 1'b0, 1'b0, 0, 1'b0);
    send_frame("noovr3", 8'h33, 1'b0, 1'b0, 0, 1'b1);
    pop("noovr.ack1");
    pop("noovr.ack2");

    // Reset mid-frame with a word already buffered.
    send_frame("prerst", 8'h77, 1'b0, 1'b0, 0, 1'b0);
    shift = 1'b1;
    serial_data = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      serial_data = 1'($urandom);
      @(posedge clk); #1;
    end
    shift = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    check_outputs("midrst", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame("postrst", 8'hC3, 1'b0, 1'b0, 0, 1'b0);
    pop("postrst.ack");

    // Randomized frames with error injection, gaps and acks.
    for (int n = 0; n < 60; n++) begin
      d  = W'($urandom);
      pf = ($urandom_range(9, 0) == 0);
      sb = ($urandom_range(9, 0) == 0);
      ak = ($urandom_range(2, 0) == 0);
      send_frame("rand", d, pf, sb, int'($urandom_range(2, 0)), ak);
      if ($urandom_range(3, 0) == 0) pop("rand.ack");
      if ($urandom_range(3, 0) == 0) idle_zeros("rand.idle", int'($urandom_range(2, 1)));
    end
    while (q.size() > 0) pop("drain");
    check_outputs("final", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/receive_shift_register.md
# receive_shift_register

Serial-to-parallel receiver for the single-wire link driven by the transceiver's transmit shift register. It samples one bit per `shift` strobe and delineates frames with a start/parity/stop structure. Completed words go into a two-entry output buffer presented with a valid/acknowledge handshake. It sits on the receive side of the transceiver, between the serial line and the consuming logic.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame (minimum 2).
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `serial_data`  input  1  serial line; idle level 0; sampled only when `shift`=1.
- `shift`  input  1  bit strobe; one line bit is consumed per clock with `shift`=1.
- `paralel_data`  output  DATA_WIDTH  head word of the output buffer; 0 when the buffer is empty.
- `data_valid`  output  1  buffer non-empty.
- `data_ack`  input  1  consumer pops the head word; ignored when `data_valid`=0.
- `parity_error`  output  1  one-cycle pulse; frame dropped due to parity mismatch.
- `framing_error`  output  1  one-cycle pulse; frame dropped due to bad stop bit.
- `overrun_error`  output  1  one-cycle pulse; good frame dropped because the buffer was full.

## Operation
- Frame on the line, in order: start bit 1, DATA_WIDTH data bits (LSB first), parity bit, stop bit 0. Parity is even: the parity bit equals the XOR of the data bits.
- FSM states are IDLE, DATA, PARITY and STOP. The FSM advances only on cycles with `shift`=1 and holds everything when `shift`=0.
- IDLE: a sampled 1 moves the FSM to DATA, clearing the bit counter and shift register. A sampled 0 leaves it in IDLE.
- DATA: each sample does `sreg <= {serial_data, sreg[DATA_WIDTH-1:1]}` and increments the counter. The sample with counter = DATA_WIDTH-1 moves the FSM to PARITY. The counter is `$clog2(DATA_WIDTH)` bits wide and does not wrap within a frame.
- PARITY: registers `par_ok = (serial_data == ^sreg)`, then moves to STOP.
- STOP, sampled 1: drop the word, pulse `framing_error` (this takes precedence over parity), go to IDLE. The stop bit is never reinterpreted as a start.
- STOP, sampled 0 with `par_ok`=0: drop the word, pulse `parity_error`, go to IDLE.
- STOP, sampled 0 with `par_ok`=1: push `sreg` into the buffer, go to IDLE.
- Buffer is a 2-entry FIFO with a count of 0..2 and is read oldest-first.
- Push and pop in the same cycle: always legal, including at count 2 (the pop frees the slot, so no overrun) and at count 0 (a pop at count 0 is ignored).
- Push while full without a pop: the new word is dropped, `overrun_error` pulses, and buffer contents are unchanged.
- Error pulses last exactly one cycle, are never sticky, and are mutually exclusive per frame.
- Reset mid-frame: everything returns to its reset value immediately and the partial frame is discarded. After reset release, reception resumes at the next 1 sampled in IDLE.

## Timing
- Reset values: state IDLE, counter 0, `sreg` 0, buffer count 0, `paralel_data` 0, `data_valid` 0, all error outputs 0.
- All outputs are registered or decoded from registers. There are no combinational paths from `serial_data`, `shift` or `data_ack` to any output.
- Push latency: the word is written on the edge that samples the stop bit. From the cycle after that edge, `data_valid`=1 and `paralel_data` shows the word (if the buffer was empty).
- Error pulses are high for the single cycle after the edge that samples the stop bit.
- Pop: with `data_valid`=1 and `data_ack`=1 at an edge, the next entry (or 0 with `data_valid`=0) appears in the following cycle.
- Minimum frame length is DATA_WIDTH+3 strobes. Back-to-back frames are accepted, with the start bit immediately following the stop bit.

## Test plan
- Basic frame, DATA_WIDTH=8, `shift` every cycle: send 1, 1,0,1,0,0,1,0,1, 0, 0. Required: `paralel_data`=0xA5 and `data_valid`=1 the cycle after the stop edge, and no error pulses. Holding `data_ack` for one cycle then gives `data_valid`=0 and `paralel_data`=0.
- Gapped strobe: the same 0xA5 frame with `shift` low for 0..5 random cycles between bits. Required: identical result; `serial_data` toggling while `shift`=0 is ignored.
- Parity error: send 0x01 with parity bit 0. Required: a single `parity_error` pulse and `data_valid` stays 0. A following frame of 0x03 with parity 0 is received correctly.
- Framing error: 0x5A with correct parity and stop bit 1. Required: a `framing_error` pulse, nothing pushed, and the FSM in IDLE (a following 0 does not start a frame).
- Overrun: back-to-back frames 0x11, 0x22, 0x33 with no ack. Required: `overrun_error` pulses on 0x33, and acks then return 0x11 then 0x22. A second run with `data_ack` asserted on the 0x33 push cycle must show no overrun, with output sequence 0x11, 0x22, 0x33.
- Reset mid-frame: deassert `rst_n` after 4 data bits of a frame. Required: all outputs at reset values, and a full frame of 0xC3 after release is received as 0xC3.
